// File: rtl/serial_chan_mux_pkg.sv
// Shared definitions for the serial channel multiplexer: header layout, FSM states and
// the header builder.
package serial_chan_mux_pkg;

    localparam int unsigned HDR_LEN_LSB  = 0;
    localparam int unsigned HDR_LEN_W    = 8;
    localparam int unsigned HDR_CHAN_LSB = 8;
    localparam int unsigned HDR_CHAN_W   = 8;
    localparam int unsigned HDR_PAD_LSB  = 16;
    localparam int unsigned MAX_LEN      = 256;

    typedef enum logic [1:0] {T_IDLE, T_HDR, T_PAY} tx_state_t;
    typedef enum logic [1:0] {R_HDR, R_PAY, R_DROP} rx_state_t;

    // Length is carried as len-1 so that a full 256-word burst fits in eight bits.
    function automatic logic [15:0] mk_header(input logic [7:0] chan, input logic [8:0] len);
        return {chan, 8'(len - 9'd1)};
    endfunction

endpackage

// File: rtl/serial_chan_mux_fifo.sv
// Synchronous FIFO with occupancy count; full/empty status derive only from the
// registered count.
module msg_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // A push on full is refused even if a pop happens in the same cycle.
    assign full    = (count == CNTW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_chan_mux.sv
// Multiplexes NCHAN virtual channels onto one framed word pipe: round-robin TX bursts out,
// header-parsed RX bursts demultiplexed into per-channel FIFOs.
module serial_chan_mux
    import serial_chan_mux_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NCHAN     = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                     sys_clk_pin,
    input  logic                     sys_rst_pin,
    output logic [WIDTH-1:0]         msg_out_get,
    output logic                     RDY_msg_out_get,
    input  logic                     EN_msg_out_get,
    input  logic [WIDTH-1:0]         msg_in_put,
    output logic                     RDY_msg_in_put,
    input  logic                     EN_msg_in_put,
    input  logic [NCHAN*WIDTH-1:0]   chan_tx_put,
    output logic [NCHAN-1:0]         RDY_chan_tx_put,
    input  logic [NCHAN-1:0]         EN_chan_tx_put,
    output logic [NCHAN*WIDTH-1:0]   chan_rx_get,
    output logic [NCHAN-1:0]         RDY_chan_rx_get,
    input  logic [NCHAN-1:0]         EN_chan_rx_get,
    output logic [15:0]              drop_count
);
    localparam int unsigned CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1;
    localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;

    logic             live;
    logic [WIDTH-1:0] tx_head [NCHAN];
    logic [WIDTH-1:0] rx_head [NCHAN];
    logic [CNTW-1:0]  tx_cnt  [NCHAN];
    logic [CNTW-1:0]  rx_cnt  [NCHAN];
    logic [NCHAN-1:0] tx_full, rx_full, tx_push, tx_pop, rx_push, rx_pop;

    tx_state_t        tx_state;
    logic [CHW-1:0]   tx_chan, rr_ptr, scan_chan;
    logic [LEN_W-1:0] tx_len, tx_rem, scan_len;
    logic             scan_found, tx_take;

    rx_state_t        rx_state;
    logic [CHW-1:0]   rx_chan;
    logic [LEN_W-1:0] rx_rem, hdr_len;
    logic [7:0]       hdr_chan;
    logic             hdr_bad, rx_take;

    // Holds every RDY low for as long as reset is sampled asserted.
    always_ff @(posedge sys_clk_pin) begin
        live <= sys_rst_pin;
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        assign tx_push[i] = EN_chan_tx_put[i] & RDY_chan_tx_put[i];
        assign tx_pop[i]  = tx_take & (tx_state == T_PAY) & (tx_chan == CHW'(i));
        assign rx_push[i] = rx_take & (rx_state == R_PAY) & (rx_chan == CHW'(i));
        assign rx_pop[i]  = EN_chan_rx_get[i] & RDY_chan_rx_get[i];

        assign RDY_chan_tx_put[i]              = live & ~tx_full[i];
        assign RDY_chan_rx_get[i]              = live & (rx_cnt[i] != '0);
        assign chan_rx_get[i*WIDTH +: WIDTH]   = rx_head[i];

        msg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
            .clk       (sys_clk_pin),
            .rst_n     (sys_rst_pin),
            .push      (tx_push[i]),
            .push_data (chan_tx_put[i*WIDTH +: WIDTH]),
            .pop       (tx_pop[i]),
            .head      (tx_head[i]),
            .count     (tx_cnt[i]),
            .full      (tx_full[i])
        );

        msg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
            .clk       (sys_clk_pin),
            .rst_n     (sys_rst_pin),
            .push      (rx_push[i]),
            .push_data (msg_in_put),
            .pop       (rx_pop[i]),
            .head      (rx_head[i]),
            .count     (rx_cnt[i]),
            .full      (rx_full[i])
        );
    end

    function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NCHAN) s = s - NCHAN;
        return CHW'(s);
    endfunction

    // First non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        scan_found = 1'b0;
        scan_chan  = '0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            if (!scan_found && tx_cnt[rr_idx(rr_ptr, i)] != '0) begin
                scan_found = 1'b1;
                scan_chan  = rr_idx(rr_ptr, i);
            end
        end
        if (32'(tx_cnt[scan_chan]) > MAX_BURST) scan_len = LEN_W'(MAX_BURST);
        else                                    scan_len = LEN_W'(tx_cnt[scan_chan]);
    end

    assign RDY_msg_out_get = live & (tx_state != T_IDLE);
    assign tx_take         = RDY_msg_out_get & EN_msg_out_get;

    always_comb begin
        msg_out_get = '0;
        if (tx_state == T_HDR)      msg_out_get = WIDTH'(mk_header(8'(tx_chan), tx_len));
        else if (tx_state == T_PAY) msg_out_get = tx_head[tx_chan];
    end

    always_ff @(posedge sys_clk_pin) begin
        if (!sys_rst_pin) begin
            tx_state <= T_IDLE;
            tx_chan  <= '0;
            tx_len   <= '0;
            tx_rem   <= '0;
            rr_ptr   <= '0;
        end else begin
            unique case (tx_state)
                T_IDLE: if (scan_found) begin
                    tx_chan  <= scan_chan;
                    tx_len   <= scan_len;
                    tx_state <= T_HDR;
                end
                T_HDR: if (tx_take) begin
                    tx_rem   <= tx_len;
                    tx_state <= T_PAY;
                end
                T_PAY: if (tx_take) begin
                    tx_rem <= tx_rem - LEN_W'(1);
                    if (tx_rem == LEN_W'(1)) begin
                        tx_state <= T_IDLE;
                        rr_ptr   <= rr_idx(tx_chan, 1);
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    assign hdr_chan = msg_in_put[HDR_CHAN_LSB +: HDR_CHAN_W];
    assign hdr_len  = LEN_W'(msg_in_put[HDR_LEN_LSB +: HDR_LEN_W]) + LEN_W'(1);
    assign hdr_bad  = (32'(hdr_chan) >= NCHAN) | (msg_in_put[WIDTH-1:HDR_PAD_LSB] != '0);

    // Only payload for a live channel can stall; headers and dropped words always flow.
    assign RDY_msg_in_put = live & ((rx_state == R_PAY) ? ~rx_full[rx_chan] : 1'b1);
    assign rx_take        = RDY_msg_in_put & EN_msg_in_put;

    always_ff @(posedge sys_clk_pin) begin
        if (!sys_rst_pin) begin
            rx_state   <= R_HDR;
            rx_chan    <= '0;
            rx_rem     <= '0;
            drop_count <= '0;
        end else begin
            unique case (rx_state)
                R_HDR: if (rx_take) begin
                    rx_chan <= CHW'(hdr_chan);
                    rx_rem  <= hdr_len;
                    if (hdr_bad) begin
                        rx_state <= R_DROP;
                        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                    end else begin
                        rx_state <= R_PAY;
                    end
                end
                R_PAY, R_DROP: if (rx_take) begin
                    rx_rem <= rx_rem - LEN_W'(1);
                    if (rx_rem == LEN_W'(1)) rx_state <= R_HDR;
                end
                default: rx_state <= R_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_chan_mux.sv
// Self-checking bench for serial_chan_mux: directed framing/arbitration/drop/reset cases
// plus randomized traffic checked against per-channel queue models.
module tb_serial_chan_mux;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int D  = 16;
    localparam int MB = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   msg_out_get;
    logic           RDY_msg_out_get;
    logic           EN_msg_out_get = 1'b0;
    logic [W-1:0]   msg_in_put = '0;
    logic           RDY_msg_in_put;
    logic           EN_msg_in_put = 1'b0;
    logic [N*W-1:0] chan_tx_put = '0;
    logic [N-1:0]   RDY_chan_tx_put;
    logic [N-1:0]   EN_chan_tx_put = '0;
    logic [N*W-1:0] chan_rx_get;
    logic [N-1:0]   RDY_chan_rx_get;
    logic [N-1:0]   EN_chan_rx_get = '0;
    logic [15:0]    drop_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] txq[N][$];
    logic [31:0] rxq[N][$];
    logic [31:0] stream[$];

    always #5 clk = ~clk;

    serial_chan_mux #(.WIDTH(W), .NCHAN(N), .DEPTH(D), .MAX_BURST(MB)) dut (
        .sys_clk_pin     (clk),
        .sys_rst_pin     (rst_n),
        .msg_out_get     (msg_out_get),
        .RDY_msg_out_get (RDY_msg_out_get),
        .EN_msg_out_get  (EN_msg_out_get),
        .msg_in_put      (msg_in_put),
        .RDY_msg_in_put  (RDY_msg_in_put),
        .EN_msg_in_put   (EN_msg_in_put),
        .chan_tx_put     (chan_tx_put),
        .RDY_chan_tx_put (RDY_chan_tx_put),
        .EN_chan_tx_put  (EN_chan_tx_put),
        .chan_rx_get     (chan_rx_get),
        .RDY_chan_rx_get (RDY_chan_rx_get),
        .EN_chan_rx_get  (EN_chan_rx_get),
        .drop_count      (drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        EN_msg_out_get = 0; EN_msg_in_put = 0; EN_chan_tx_put = '0; EN_chan_rx_get = '0;
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
    endtask

    task automatic push_tx(input int ch, input logic [31:0] data);
        chan_tx_put[ch*W +: W] = data;
        EN_chan_tx_put = N'(1) << ch;
        tick();
        EN_chan_tx_put = '0;
    endtask

    task automatic get_out(output logic [31:0] d, output bit ok);
        int k = 0;
        ok = 0; d = '0;
        while (!RDY_msg_out_get && k < 100) begin tick(); k++; end
        if (RDY_msg_out_get) begin
            d = msg_out_get; ok = 1;
            EN_msg_out_get = 1; tick(); EN_msg_out_get = 0;
        end
    endtask

    task automatic put_in(input logic [31:0] w, output bit ok);
        int k = 0;
        ok = 0;
        while (!RDY_msg_in_put && k < 100) begin tick(); k++; end
        if (RDY_msg_in_put) begin
            msg_in_put = w; ok = 1;
            EN_msg_in_put = 1; tick(); EN_msg_in_put = 0;
        end
    endtask

    task automatic pop_rx(input int ch, output logic [31:0] d, output bit ok);
        int k = 0;
        ok = 0; d = '0;
        while (!RDY_chan_rx_get[ch] && k < 100) begin tick(); k++; end
        if (RDY_chan_rx_get[ch]) begin
            d = chan_rx_get[ch*W +: W]; ok = 1;
            EN_chan_rx_get = N'(1) << ch; tick(); EN_chan_rx_get = '0;
        end
    endtask

    task automatic drain_expect(input string name);
        logic [31:0] d;
        bit ok;
        foreach (exp_q[i]) begin
            get_out(d, ok);
            n_cmp++;
            if (!ok || d !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s[%0d] got %h (valid %0d) expected %h", name, i, d, ok, exp_q[i]);
            end
        end
        repeat (3) tick();
        n_cmp++;
        if (RDY_msg_out_get !== 1'b0) begin
            n_err++; $display("FAIL %s_idle RDY_msg_out_get got %b expected 0", name, RDY_msg_out_get);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) tick();
        n_cmp += 6;
        if (RDY_chan_tx_put !== '0) begin n_err++; $display("FAIL rst_tx_rdy got %h expected 0", RDY_chan_tx_put); end
        if (RDY_chan_rx_get !== '0) begin n_err++; $display("FAIL rst_rx_rdy got %h expected 0", RDY_chan_rx_get); end
        if (RDY_msg_out_get !== 1'b0) begin n_err++; $display("FAIL rst_out_rdy got %b expected 0", RDY_msg_out_get); end
        if (RDY_msg_in_put !== 1'b0) begin n_err++; $display("FAIL rst_in_rdy got %b expected 0", RDY_msg_in_put); end
        if (drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drop got %0d expected 0", drop_count); end
        if (msg_out_get !== '0) begin n_err++; $display("FAIL rst_out_data got %h expected 0", msg_out_get); end
        rst_n = 1;
        tick();
        n_cmp += 2;
        if (RDY_chan_tx_put !== 4'hF) begin n_err++; $display("FAIL rel_tx_rdy got %h expected f", RDY_chan_tx_put); end
        if (RDY_msg_in_put !== 1'b1) begin n_err++; $display("FAIL rel_in_rdy got %b expected 1", RDY_msg_in_put); end
    endtask

    // A one-word primer burst on channel 3 is held unconsumed so that later pushes queue up.
    task automatic test_single_burst();
        do_reset();
        push_tx(3, 32'h5A);
        n_cmp++;
        if (RDY_msg_out_get !== 1'b0) begin n_err++; $display("FAIL latency_early got %b expected 0", RDY_msg_out_get); end
        tick();
        n_cmp += 2;
        if (RDY_msg_out_get !== 1'b1) begin n_err++; $display("FAIL latency_hdr got %b expected 1", RDY_msg_out_get); end
        if (msg_out_get !== 32'h300) begin n_err++; $display("FAIL primer_hdr got %h expected 00000300", msg_out_get); end
        push_tx(2, 32'h11); push_tx(2, 32'h22); push_tx(2, 32'h33);
        n_cmp++;
        if (msg_out_get !== 32'h300) begin n_err++; $display("FAIL hold_stable got %h expected 00000300", msg_out_get); end
        exp_q = '{32'h300, 32'h5A, 32'h202, 32'h11, 32'h22, 32'h33};
        drain_expect("single_burst");
    endtask

    task automatic test_round_robin();
        do_reset();
        push_tx(3, 32'h5A);
        for (int i = 0; i < 10; i++) begin
            chan_tx_put[0 +: W] = 32'hC00 + i;
            chan_tx_put[W +: W] = 32'h999;
            EN_chan_tx_put = (i == 0) ? 4'b0011 : 4'b0001;
            tick();
        end
        EN_chan_tx_put = '0;
        exp_q = '{32'h300, 32'h5A, 32'h007};
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hC00 + i);
        exp_q.push_back(32'h100); exp_q.push_back(32'h999);
        exp_q.push_back(32'h001); exp_q.push_back(32'hC08); exp_q.push_back(32'hC09);
        drain_expect("round_robin");
    endtask

    task automatic test_rx_backpressure();
        logic [31:0] d;
        bit ok;
        do_reset();
        put_in(32'h10F, ok);
        for (int i = 0; i < D; i++) put_in(32'hF00 + i, ok);
        put_in(32'h101, ok);
        repeat (3) tick();
        n_cmp += 2;
        if (RDY_chan_rx_get !== 4'b0010) begin n_err++; $display("FAIL bp_fill got %b expected 0010", RDY_chan_rx_get); end
        if (RDY_msg_in_put !== 1'b0) begin n_err++; $display("FAIL bp_stall got %b expected 0", RDY_msg_in_put); end
        pop_rx(1, d, ok);
        n_cmp += 2;
        if (!ok || d !== 32'hF00) begin n_err++; $display("FAIL bp_pop0 got %h expected 00000f00", d); end
        if (RDY_msg_in_put !== 1'b1) begin n_err++; $display("FAIL bp_resume got %b expected 1", RDY_msg_in_put); end
        put_in(32'hAA, ok);
        n_cmp++;
        if (RDY_msg_in_put !== 1'b0) begin n_err++; $display("FAIL bp_stall2 got %b expected 0", RDY_msg_in_put); end
        pop_rx(1, d, ok);
        put_in(32'hBB, ok);
        exp_q = '{};
        for (int i = 2; i < D; i++) exp_q.push_back(32'hF00 + i);
        exp_q.push_back(32'hAA); exp_q.push_back(32'hBB);
        foreach (exp_q[i]) begin
            pop_rx(1, d, ok);
            n_cmp++;
            if (!ok || d !== exp_q[i]) begin
                n_err++; $display("FAIL bp_data[%0d] got %h expected %h", i, d, exp_q[i]);
            end
        end
        n_cmp++;
        if (RDY_chan_rx_get !== '0 || RDY_msg_in_put !== 1'b1) begin
            n_err++; $display("FAIL bp_end rx_rdy %b in_rdy %b expected 0000/1", RDY_chan_rx_get, RDY_msg_in_put);
        end
    endtask

    task automatic test_drop();
        logic [31:0] d;
        bit ok;
        do_reset();
        put_in(32'h501, ok); put_in(32'h1, ok); put_in(32'h2, ok);
        tick();
        n_cmp += 2;
        if (drop_count !== 16'd1) begin n_err++; $display("FAIL drop_chan got %0d expected 1", drop_count); end
        if (RDY_chan_rx_get !== '0) begin n_err++; $display("FAIL drop_no_rx got %b expected 0", RDY_chan_rx_get); end
        put_in(32'h0001_0000, ok); put_in(32'h3, ok);
        put_in(32'h0, ok); put_in(32'h77, ok);
        pop_rx(0, d, ok);
        n_cmp += 2;
        if (!ok || d !== 32'h77) begin n_err++; $display("FAIL drop_next got %h expected 00000077", d); end
        if (drop_count !== 16'd2) begin n_err++; $display("FAIL drop_pad got %0d expected 2", drop_count); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit ok;
        do_reset();
        push_tx(2, 32'hA1);
        get_out(d, ok); get_out(d, ok);
        push_tx(1, 32'hB1);
        get_out(d, ok);
        n_cmp++;
        if (!ok || d !== 32'h100) begin n_err++; $display("FAIL mid_pre_hdr got %h expected 00000100", d); end
        put_in(32'h103, ok); put_in(32'hC1, ok);
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
        n_cmp += 4;
        if (RDY_msg_out_get !== 1'b0) begin n_err++; $display("FAIL mid_out_rdy got %b expected 0", RDY_msg_out_get); end
        if (RDY_chan_rx_get !== '0) begin n_err++; $display("FAIL mid_rx_empty got %b expected 0", RDY_chan_rx_get); end
        if (RDY_msg_in_put !== 1'b1) begin n_err++; $display("FAIL mid_in_rdy got %b expected 1", RDY_msg_in_put); end
        if (RDY_chan_tx_put !== 4'hF) begin n_err++; $display("FAIL mid_tx_rdy got %h expected f", RDY_chan_tx_put); end
        chan_tx_put[0 +: W] = 32'hD0;
        chan_tx_put[3*W +: W] = 32'hD3;
        EN_chan_tx_put = 4'b1001;
        tick();
        EN_chan_tx_put = '0;
        exp_q = '{32'h000, 32'hD0, 32'h300, 32'hD3};
        drain_expect("mid_rr");
        put_in(32'h200, ok); put_in(32'h55, ok);
        pop_rx(2, d, ok);
        n_cmp += 2;
        if (!ok || d !== 32'h55) begin n_err++; $display("FAIL mid_rx_hdr got %h expected 00000055", d); end
        if (RDY_chan_rx_get !== '0) begin n_err++; $display("FAIL mid_rx_clean got %b expected 0", RDY_chan_rx_get); end
    endtask

    task automatic test_random_tx();
        bit in_pay = 0;
        int cur = 0, rem = 0, hlen, hch;
        logic [31:0] w;
        logic [N-1:0] mask;
        do_reset();
        for (int ch = 0; ch < N; ch++) txq[ch].delete();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            EN_msg_out_get = 0;
            if (RDY_msg_out_get && $urandom_range(0, 3) != 0) begin
                w = msg_out_get;
                EN_msg_out_get = 1;
                n_cmp++;
                if (!in_pay) begin
                    hch = int'(w[15:8]); hlen = int'(w[7:0]) + 1;
                    if (w[31:16] !== 16'h0 || hch >= N || hlen > MB || hlen > txq[hch].size()) begin
                        n_err++; $display("FAIL rand_tx_hdr got %h", w);
                    end else begin
                        in_pay = 1; cur = hch; rem = hlen;
                    end
                end else begin
                    if (txq[cur].size() == 0 || w !== txq[cur][0]) begin
                        n_err++; $display("FAIL rand_tx_data ch%0d got %h expected %h", cur, w,
                                          txq[cur].size() ? txq[cur][0] : 32'hX);
                    end
                    if (txq[cur].size() != 0) void'(txq[cur].pop_front());
                    rem--;
                    if (rem == 0) in_pay = 0;
                end
            end
            mask = (cyc < 200) ? (N'($urandom) & RDY_chan_tx_put) : '0;
            for (int ch = 0; ch < N; ch++) begin
                if (mask[ch]) begin
                    w = $urandom;
                    chan_tx_put[ch*W +: W] = w;
                    txq[ch].push_back(w);
                end
            end
            EN_chan_tx_put = mask;
            tick();
        end
        EN_msg_out_get = 0; EN_chan_tx_put = '0;
        for (int ch = 0; ch < N; ch++) begin
            n_cmp++;
            if (txq[ch].size() != 0) begin
                n_err++; $display("FAIL rand_tx_drain ch%0d left %0d expected 0", ch, txq[ch].size());
            end
        end
    endtask

    task automatic test_random_rx();
        int exp_drop = 0;
        int ch, len;
        bit bad;
        logic [31:0] hdr, w;
        logic [N-1:0] mask;
        do_reset();
        stream.delete();
        for (int c = 0; c < N; c++) rxq[c].delete();
        for (int b = 0; b < 30; b++) begin
            bad = ($urandom_range(0, 4) == 0);
            ch  = $urandom_range(0, N - 1);
            len = $urandom_range(1, 6);
            hdr = {16'h0, 8'(ch), 8'(len - 1)};
            if (bad) begin
                if ($urandom_range(0, 1) == 1) hdr[15:8] = 8'($urandom_range(N, 255));
                else hdr[31:16] = 16'($urandom_range(1, 65535));
                exp_drop++;
            end
            stream.push_back(hdr);
            for (int k = 0; k < len; k++) begin
                w = $urandom;
                stream.push_back(w);
                if (!bad) rxq[ch].push_back(w);
            end
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            EN_msg_in_put = 0;
            if (stream.size() != 0 && RDY_msg_in_put && $urandom_range(0, 3) != 0) begin
                msg_in_put = stream.pop_front();
                EN_msg_in_put = 1;
            end
            mask = '0;
            for (int c = 0; c < N; c++) begin
                if (RDY_chan_rx_get[c] && $urandom_range(0, 2) == 0) begin
                    w = chan_rx_get[c*W +: W];
                    mask[c] = 1'b1;
                    n_cmp++;
                    if (rxq[c].size() == 0 || w !== rxq[c][0]) begin
                        n_err++; $display("FAIL rand_rx_data ch%0d got %h expected %h", c, w,
                                          rxq[c].size() ? rxq[c][0] : 32'hX);
                    end
                    if (rxq[c].size() != 0) void'(rxq[c].pop_front());
                end
            end
            EN_chan_rx_get = mask;
            tick();
        end
        EN_msg_in_put = 0; EN_chan_rx_get = '0;
        n_cmp += 2;
        if (stream.size() != 0) begin n_err++; $display("FAIL rand_rx_stall left %0d expected 0", stream.size()); end
        if (drop_count !== 16'(exp_drop)) begin
            n_err++; $display("FAIL rand_rx_drops got %0d expected %0d", drop_count, exp_drop);
        end
        for (int c = 0; c < N; c++) begin
            n_cmp++;
            if (rxq[c].size() != 0) begin
                n_err++; $display("FAIL rand_rx_drain ch%0d left %0d expected 0", c, rxq[c].size());
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_rx_backpressure();
        test_drop();
        test_reset_mid();
        test_random_tx();
        test_random_rx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
